rmii_tx: RTL



---
 rtl/rmii_tx_pkg.sv | 44 ++++
 rtl/rmii_tx_crc32_dibit.sv | 36 +++
 rtl/rmii_tx.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/rmii_tx_pkg.sv
// rtl/rmii_tx_pkg.sv - frame constants, FSM state type and CRC-32 dibit step for the RMII transmitter
//
// Contents:
//   state_e           transmit FSM states
//   PREAMBLE_DIBITS   number of 2'b01 dibits before the SFD
//   SFD_BYTE          start-of-frame delimiter, sent LSB dibit first
//   IFG_CYCLES        inter-frame gap length in clocks
//   FCS_DIBITS        FCS length in dibits
//   CRC_POLY/INIT     reflected CRC-32 polynomial and seed
//   crc32_step_dibit  advances a reflected CRC-32 by two bits, d[0] first

package rmii_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_PAYLOAD,
        ST_FCS,
        ST_GAP
    } state_e;

    localparam int          PREAMBLE_DIBITS = 28;
    localparam logic [7:0]  SFD_BYTE        = 8'hD5;
    localparam int          IFG_CYCLES      = 48;
    localparam int          FCS_DIBITS      = 16;
    localparam logic [31:0] CRC_POLY        = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT        = 32'hFFFFFFFF;

    function automatic logic [31:0] crc32_step_dibit(input logic [31:0] crc,
                                                     input logic [1:0]  d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 2; i++) begin
            if (c[0] ^ d[i]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/rmii_tx_crc32_dibit.sv
// rtl/rmii_tx_crc32_dibit.sv - reflected CRC-32 register advanced two bits per clock
//
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset (loads CRC_INIT)
//   clr  in   reload CRC_INIT (start of a new frame)
//   en   in   fold d into the register this clock
//   d    in   dibit, bit 0 is the earlier bit on the wire
//   crc  out  current register value (not complemented)

module crc32_dibit
    import rmii_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [1:0]  d,
    output logic [31:0] crc
);

    logic [31:0] crc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= CRC_INIT;
        end else if (clr) begin
            crc_q <= CRC_INIT;
        end else if (en) begin
            crc_q <= crc32_step_dibit(crc_q, d);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/rmii_tx.sv
// rtl/rmii_tx.sv - RMII transmit framer: preamble, SFD, payload dibits, FCS, inter-frame gap
//
// Ports:
//   clk       in   50 MHz RMII reference clock
//   rst       in   synchronous active-high reset
//   axiiv     in   payload byte valid
//   axiid     in   payload byte
//   axiilast  in   marks axiid as the final payload byte
//   axiir     out  ready; a byte transfers when axiiv && axiir
//   axiov     out  TXEN (registered)
//   axiod     out  TXD[1:0] (registered, 2'b00 while TXEN is low)
//   underrun  out  single-cycle pulse when the next byte is missing mid-frame

module rmii_tx
    import rmii_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [7:0] axiid,
    input  logic       axiilast,
    output logic       axiir,
    output logic       axiov,
    output logic [1:0] axiod,
    output logic       underrun
);

    // state_q names what is on the wire during the current cycle
    state_e      state_q, state_d;
    logic [5:0]  cnt_q,   cnt_d;
    logic [1:0]  idx_q,   idx_d;
    logic [7:0]  hold_q,  hold_d;
    logic        last_q,  last_d;
    logic [31:0] fcs_q,   fcs_d;
    logic        axiov_q, axiov_d;
    logic [1:0]  axiod_q, axiod_d;

    logic [31:0] crc;
    logic [1:0]  cur_dibit;
    logic        ready_window;
    logic        accept;
    logic        crc_clr;
    logic        crc_en;

    assign cur_dibit    = hold_q[{idx_q, 1'b0} +: 2];

    // The only mid-frame chance to fetch a byte is the last dibit of a non-final byte
    assign ready_window = (state_q == ST_PAYLOAD) && (idx_q == 2'd3) && !last_q;
    assign axiir        = !rst && ((state_q == ST_IDLE) || ready_window);
    assign accept       = axiiv && axiir;
    assign underrun     = !rst && ready_window && !axiiv;

    assign crc_clr      = (state_q == ST_IDLE) && accept;
    assign crc_en       = (state_q == ST_PAYLOAD);

    crc32_dibit u_crc (
        .clk (clk),
        .rst (rst),
        .clr (crc_clr),
        .en  (crc_en),
        .d   (cur_dibit),
        .crc (crc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            last_q  <= 1'b0;
            fcs_q   <= '0;
            axiov_q <= 1'b0;
            axiod_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            fcs_q   <= fcs_d;
            axiov_q <= axiov_d;
            axiod_q <= axiod_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        last_d  = last_q;
        fcs_d   = fcs_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    hold_d  = axiid;
                    last_d  = axiilast;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                if (cnt_q == 6'(PREAMBLE_DIBITS - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_SFD;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_SFD: begin
                if (cnt_q == 6'd3) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_PAYLOAD;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_PAYLOAD: begin
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    cnt_d = '0;
                    if (last_q) begin
                        // The CRC register only absorbs this dibit at the edge, so fold it in here
                        fcs_d   = ~crc32_step_dibit(crc, cur_dibit);
                        state_d = ST_FCS;
                    end else if (axiiv) begin
                        hold_d = axiid;
                        last_d = axiilast;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_FCS: begin
                fcs_d = fcs_q >> 2;
                if (cnt_q == 6'(FCS_DIBITS - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 6'(IFG_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pins are decoded from the next state so TXEN/TXD come straight from flops
    always_comb begin
        axiov_d = 1'b0;
        axiod_d = 2'b00;
        case (state_d)
            ST_PREAMBLE: begin
                axiov_d = 1'b1;
                axiod_d = 2'b01;
            end
            ST_SFD: begin
                axiov_d = 1'b1;
                axiod_d = SFD_BYTE[{cnt_d[1:0], 1'b0} +: 2];
            end
            ST_PAYLOAD: begin
                axiov_d = 1'b1;
                axiod_d = hold_d[{idx_d, 1'b0} +: 2];
            end
            ST_FCS: begin
                axiov_d = 1'b1;
                axiod_d = fcs_d[1:0];
            end
            default: begin
                axiov_d = 1'b0;
                axiod_d = 2'b00;
            end
        endcase
    end

    assign axiov = axiov_q;
    assign axiod = axiod_q;

endmodule
